// File: rtl/mini16sc_pkg.sv
// mini16sc_pkg: shared constants and the in-flight tag type for the mini16sc memory arbiter.
package mini16sc_pkg;
   localparam int N_PORTS_DEF = 4;
   localparam int MAX_PORTS   = 8;
   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;
   localparam int PORT_W      = $clog2(MAX_PORTS);
   typedef struct packed {
      logic              valid;
      logic              is_read;
      logic [PORT_W-1:0] port;
   } tag_t;
endpackage

// File: rtl/mini16sc_rr_pick.sv
// mini16sc_rr_pick: combinational round-robin pick, first requester at or after ptr (wrapping).
module mini16sc_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [IW-1:0] p;
   // Scan farthest-first so the nearest requester to ptr is the last (winning) assignment.
   always_comb begin
      grant = '0;
      idx = '0;
      any = 1'b0;
      p = '0;
      for (int k = N - 1; k >= 0; k--) begin
         p = IW'((int'(ptr) + k) % N);
         if (req[p]) begin
            grant = '0;
            grant[p] = 1'b1;
            idx = p;
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mini16sc_mem_arbiter.sv
// mini16sc_mem_arbiter: round-robin arbiter sharing one RAM port among N_PORTS cores,
// with a tag pipeline routing read data back to the requester in acceptance order.
module mini16sc_mem_arbiter
   import mini16sc_pkg::*;
#(
   parameter int N_PORTS     = N_PORTS_DEF,
   parameter int WIDTH_D     = 16,
   parameter int DEPTH_D     = 12,
   parameter int MEM_LATENCY = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_PORTS-1:0]         req_valid,
   output logic [N_PORTS-1:0]         req_ready,
   input  logic [N_PORTS-1:0]         req_we,
   input  logic [N_PORTS*DEPTH_D-1:0] req_addr,
   input  logic [N_PORTS*WIDTH_D-1:0] req_wdata,
   output logic [N_PORTS-1:0]         resp_valid,
   output logic [WIDTH_D-1:0]         resp_data,
   output logic [DEPTH_D-1:0]         mem_addr,
   output logic [WIDTH_D-1:0]         mem_wdata,
   output logic                       mem_we,
   input  logic [WIDTH_D-1:0]         mem_rdata
);
   localparam int IW = $clog2(N_PORTS);
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      win;
   logic [N_PORTS-1:0] grant;
   logic               any;
   logic               ret;
   tag_t               tags [MEM_LATENCY+1];
   mini16sc_rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
      .req  (req_valid),
      .ptr  (rr_ptr),
      .grant(grant),
      .idx  (win),
      .any  (any)
   );
   assign req_ready = reset ? '0 : grant;
   // The last tag stage lines up with mem_rdata for the operation it describes.
   assign ret = tags[MEM_LATENCY].valid & tags[MEM_LATENCY].is_read;
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         resp_valid <= '0;
         resp_data <= '0;
         for (int k = 0; k <= MEM_LATENCY; k++) tags[k] <= '0;
      end else begin
         mem_we <= any & req_we[win];
         if (any) begin
            mem_addr <= req_addr[win*DEPTH_D +: DEPTH_D];
            mem_wdata <= req_wdata[win*WIDTH_D +: WIDTH_D];
            rr_ptr <= (win == IW'(N_PORTS - 1)) ? '0 : win + 1'b1;
         end
         tags[0] <= '{valid: any, is_read: ~req_we[win], port: PORT_W'(win)};
         for (int k = 1; k <= MEM_LATENCY; k++) tags[k] <= tags[k-1];
         resp_valid <= ret ? N_PORTS'(1) << tags[MEM_LATENCY].port : '0;
         if (ret) resp_data <= mem_rdata;
      end
   end
endmodule

// File: doc/mini16sc_mem_arbiter.md
MINI16SC_MEM_ARBITER -- requirements
Module: mini16sc_mem_arbiter

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 4, meaning the number of requesting cores (2..8).
REQ-002 The block SHALL have parameter WIDTH_D, default 16, meaning the data width.
REQ-003 The block SHALL have parameter DEPTH_D, default 12, meaning the shared-memory address width.
REQ-004 The block SHALL have parameter MEM_LATENCY, default 1, meaning the shared RAM read latency in cycles (1..4).
REQ-005 The block SHALL have port clk  in  1  clock.
REQ-006 The block SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-007 The block SHALL have port req_valid  in  N_PORTS  per-port request.
REQ-008 The block SHALL have port req_ready  out  N_PORTS  per-port accept, one-hot or zero.
REQ-009 The block SHALL have port req_we  in  N_PORTS  per-port write flag (1 = write, 0 = read).
REQ-010 The block SHALL have port req_addr  in  N_PORTS*DEPTH_D  packed addresses, port i at slice [i*DEPTH_D +: DEPTH_D].
REQ-011 The block SHALL have port req_wdata  in  N_PORTS*WIDTH_D  packed write data.
REQ-012 The block SHALL have port resp_valid  out  N_PORTS  read-data strobe, one-hot or zero.
REQ-013 The block SHALL have port resp_data  out  WIDTH_D  read data, shared by all ports.
REQ-014 The block SHALL have ports mem_addr  out  DEPTH_D, mem_wdata  out  WIDTH_D, mem_we  out  1, and mem_rdata  in  WIDTH_D, together forming the shared RAM port.

Function
REQ-015 In cycle T, req_ready[i] SHALL be high only if req_valid[i]=1 and i is the first requesting port at or after rr_ptr, searching upward and wrapping modulo N_PORTS.
REQ-016 A request SHALL be accepted in cycle T when req_valid[i] & req_ready[i]; at most one acceptance per cycle.
REQ-017 On acceptance, the block SHALL drive mem_addr, mem_wdata and mem_we from the winning port in cycle T+1 (registered); in idle cycles mem_we=0 and mem_addr/mem_wdata hold.
REQ-018 On acceptance of port i, rr_ptr SHALL become (i+1) mod N_PORTS in T+1; without an acceptance, rr_ptr SHALL hold.
REQ-019 Each accepted read SHALL produce exactly one resp_valid[i] pulse in cycle T+2+MEM_LATENCY, with resp_data = mem_rdata sampled at T+1+MEM_LATENCY, registered.
REQ-020 Writes SHALL produce no response.
REQ-021 A tag pipeline (valid, is_read, port index) of depth 1+MEM_LATENCY SHALL track in-flight operations; back-to-back reads from any ports SHALL return in acceptance order, one per cycle.
REQ-022 req_valid deasserted before acceptance SHALL withdraw the request without side effects; a requester SHALL hold req_* stable while req_valid=1 and req_ready=0.
REQ-023 With all N_PORTS continuously requesting, each port SHALL be granted exactly once in every N_PORTS consecutive cycles (no starvation).
REQ-024 Read-after-write to the same address from any ports SHALL return the written data (RAM write in cycle T+1 precedes the later read).

Reset
REQ-025 While reset=1, the block SHALL set rr_ptr=0, clear the tag pipeline, and drive req_ready=0, resp_valid=0, resp_data=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-026 Requests in flight when reset asserts SHALL be discarded; no resp_valid SHALL appear for them after reset releases.
REQ-027 In the first cycle after reset deasserts, the block SHALL accept requests with port 0 highest priority.

Structure
REQ-028 The opcode-independent constants (default N_PORTS, MEM_LATENCY bounds) SHALL reside in shared package mini16sc_pkg.
REQ-029 The round-robin priority pick (request vector + pointer -> one-hot grant + index) SHALL be sub-module mini16sc_rr_pick, combinational.
REQ-030 req_ready SHALL be the only combinational output; all other outputs SHALL be registered.

Verification
REQ-031 Single read: port 2 reads addr 0x010 holding 0xBEEF, MEM_LATENCY=1 -> req_ready[2] same cycle, resp_valid=4'b0100 and resp_data=0xBEEF exactly 3 cycles later.
REQ-032 Full contention: all 4 ports reading continuously from rr_ptr=0 -> grants cycle 0,1,2,3,0,... and responses in the same order, one per cycle.
REQ-033 Write then read: port 0 writes 0x1234 to 0x005, next cycle port 3 reads 0x005 -> resp_valid[3] with 0x1234; no response for the write.
REQ-034 Reset mid-flight: two reads accepted, reset asserted the next cycle for 1 cycle -> no resp_valid afterwards, rr_ptr=0, all outputs 0 during reset.
REQ-035 Withdrawal: port 1 valid for 1 cycle while port 0 is granted, then dropped -> port 1 never granted, mem_we/mem_addr unaffected.
REQ-036 Latency sweep: MEM_LATENCY=3, random mixed traffic against a RAM model -> every read returns at T+5 with model data, per-port counts match.
